// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single main-memory port between instruction fetch (read only)
//   and the executor memory element (read and write). Requests are sampled in
//   IDLE. Address and data are captured at grant, so the downstream signals
//   stay stable while the memory controller works. The memory ready pulse is
//   routed combinationally back to the granted requester.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   fetch_*               fetch read channel (addr/valid in, ready/data out)
//   exec_out_*            executor read channel
//   exec_in_*             executor write channel
//   main_mem_out_*        read channel towards memory
//   main_mem_in_*         write channel towards memory
//   timeout_err           sticky watchdog flag (TIMEOUT = 0 disables it)
//
// state    | meaning
// IDLE     | no transaction; sample requests, grant on the next edge
// FETCH_RD | fetch read outstanding on main_mem_out
// EXEC_RD  | executor read outstanding on main_mem_out
// EXEC_WR  | executor write outstanding on main_mem_in
module mem_port_arbiter #(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  output logic [31:0] fetch_data,
  input  logic [31:0] exec_out_addr,
  input  logic        exec_out_valid,
  output logic        exec_out_ready,
  output logic [31:0] exec_out_data,
  input  logic [31:0] exec_in_addr,
  input  logic [31:0] exec_in_data,
  input  logic        exec_in_valid,
  output logic        exec_in_ready,
  output logic [31:0] main_mem_out_addr,
  output logic        main_mem_out_valid,
  input  logic [31:0] main_mem_out_data,
  input  logic        main_mem_out_ready,
  output logic [31:0] main_mem_in_addr,
  output logic [31:0] main_mem_in_data,
  output logic        main_mem_in_valid,
  input  logic        main_mem_in_ready,
  output logic        timeout_err
);

  localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FETCH_RD, EXEC_RD, EXEC_WR} state_t;

  state_t      state;
  logic        last_exec;      // 1: executor won the previous grant
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] fetch_data_q;
  logic [31:0] exec_data_q;
  logic [31:0] wd_cnt;
  logic        out_valid_q;
  logic        in_valid_q;
  logic        err_q;

  logic        exec_req;
  logic        grant_exec;
  logic        rd_done;
  logic        wr_done;
  logic        mem_done;

  always_comb begin
    exec_req = exec_in_valid | exec_out_valid;
    // On contention the side that did not win last time gets the port.
    if (fetch_valid && exec_req) grant_exec = ~last_exec;
    else                         grant_exec = exec_req;
    rd_done  = ((state == FETCH_RD) || (state == EXEC_RD)) && main_mem_out_ready;
    wr_done  = (state == EXEC_WR) && main_mem_in_ready;
    mem_done = rd_done | wr_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_exec    <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      fetch_data_q <= '0;
      exec_data_q  <= '0;
      out_valid_q  <= 1'b0;
      in_valid_q   <= 1'b0;
      wd_cnt       <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_valid || exec_req) begin
            wd_cnt    <= '0;
            last_exec <= grant_exec;
            if (!grant_exec) begin
              state       <= FETCH_RD;
              addr_q      <= fetch_addr;
              out_valid_q <= 1'b1;
            end else if (exec_in_valid) begin
              // executor write takes precedence over its own read
              state      <= EXEC_WR;
              addr_q     <= exec_in_addr;
              wdata_q    <= exec_in_data;
              in_valid_q <= 1'b1;
            end else begin
              state       <= EXEC_RD;
              addr_q      <= exec_out_addr;
              out_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          if (state == FETCH_RD && main_mem_out_ready) fetch_data_q <= main_mem_out_data;
          if (state == EXEC_RD && main_mem_out_ready)  exec_data_q  <= main_mem_out_data;
          if (mem_done) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_valid_q  <= 1'b0;
          end else if (TIMEOUT > 0 && wd_cnt != TIMEOUT_CNT) begin
            // counter saturates at TIMEOUT; the transaction keeps waiting
            wd_cnt <= wd_cnt + 32'd1;
            if (wd_cnt + 32'd1 == TIMEOUT_CNT) err_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign fetch_ready        = (state == FETCH_RD) && main_mem_out_ready;
  assign exec_out_ready     = (state == EXEC_RD) && main_mem_out_ready;
  assign exec_in_ready      = wr_done;
  assign fetch_data         = (state == FETCH_RD) ? main_mem_out_data : fetch_data_q;
  assign exec_out_data      = (state == EXEC_RD) ? main_mem_out_data : exec_data_q;
  assign main_mem_out_addr  = addr_q;
  assign main_mem_out_valid = out_valid_q;
  assign main_mem_in_addr   = addr_q;
  assign main_mem_in_data   = wdata_q;
  assign main_mem_in_valid  = in_valid_q;
  assign timeout_err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic [31:0] exec_out_addr;
  logic        exec_out_valid;
  logic        exec_out_ready;
  logic [31:0] exec_out_data;
  logic [31:0] exec_in_addr;
  logic [31:0] exec_in_data;
  logic        exec_in_valid;
  logic        exec_in_ready;
  logic [31:0] main_mem_out_addr;
  logic        main_mem_out_valid;
  logic [31:0] main_mem_out_data;
  logic        main_mem_out_ready;
  logic [31:0] main_mem_in_addr;
  logic [31:0] main_mem_in_data;
  logic        main_mem_in_valid;
  logic        main_mem_in_ready;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .exec_out_addr(exec_out_addr), .exec_out_valid(exec_out_valid),
    .exec_out_ready(exec_out_ready), .exec_out_data(exec_out_data),
    .exec_in_addr(exec_in_addr), .exec_in_data(exec_in_data),
    .exec_in_valid(exec_in_valid), .exec_in_ready(exec_in_ready),
    .main_mem_out_addr(main_mem_out_addr), .main_mem_out_valid(main_mem_out_valid),
    .main_mem_out_data(main_mem_out_data), .main_mem_out_ready(main_mem_out_ready),
    .main_mem_in_addr(main_mem_in_addr), .main_mem_in_data(main_mem_in_data),
    .main_mem_in_valid(main_mem_in_valid), .main_mem_in_ready(main_mem_in_ready),
    .timeout_err(timeout_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state: who was served last, and what each requester last read
  typedef enum int {NONE = 0, FETCH = 1, EXEC_READ = 2, EXEC_WRITE = 3} who_t;
  int          last_served_side;   // 0 fetch side, 1 executor side
  logic [31:0] exp_fetch_data;
  logic [31:0] exp_exec_data;

  // observations from one memory transaction
  int          obs_lat, obs_kind, obs_pulses;
  bit          obs_stable, obs_idle_after;
  logic        obs_wr;
  logic [31:0] obs_addr, obs_wdata, obs_wdata_end;
  logic [31:0] obs_fd, obs_ed, obs_fd2, obs_ed2;

  task automatic model_reset();
    last_served_side = 1;
    exp_fetch_data   = '0;
    exp_exec_data    = '0;
  endtask

  // Round-robin reference: a lone requester always wins; with both sides
  // asking, the side that was not served last time wins.
  task automatic predict(input bit f, input bit wr, input bit rd,
                         output int kind, output logic [31:0] addr, output logic [31:0] wdata);
    int side;
    side = -1;
    case ({f, (wr | rd)})
      2'b10: side = 0;
      2'b01: side = 1;
      2'b11: side = (last_served_side == 0) ? 1 : 0;
      default: side = -1;
    endcase
    if (side >= 0) last_served_side = side;
    if (side == 0)      kind = FETCH;
    else if (side == 1) kind = wr ? EXEC_WRITE : EXEC_READ;
    else                kind = NONE;
    addr  = (kind == FETCH) ? fetch_addr : (kind == EXEC_WRITE) ? exec_in_addr : exec_out_addr;
    wdata = exec_in_data;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    fetch_valid = 1'b0; exec_out_valid = 1'b0; exec_in_valid = 1'b0;
    main_mem_out_ready = 1'b0; main_mem_in_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Acts as the memory controller for one transaction. Called in the cycle
  // the requests are presented (IDLE). Returns at the IDLE cycle after ready.
  task automatic do_txn(input int delay, input logic [31:0] rdata, input bit scramble);
    obs_lat = -1; obs_kind = NONE; obs_pulses = 0; obs_stable = 1'b1; obs_idle_after = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (fetch_ready | exec_out_ready | exec_in_ready) obs_pulses++;
      if (main_mem_out_valid | main_mem_in_valid) begin
        obs_lat = i;
        break;
      end
      @(negedge clk);
    end
    if (obs_lat < 0) return;
    obs_wr    = main_mem_in_valid;
    if (main_mem_in_valid & main_mem_out_valid) obs_stable = 1'b0;
    obs_addr  = obs_wr ? main_mem_in_addr : main_mem_out_addr;
    obs_wdata = main_mem_in_data;
    if (scramble) begin
      fetch_addr = $urandom; exec_out_addr = $urandom; exec_in_addr = $urandom;
      exec_in_data = 32'h0;
    end
    for (int k = 0; k < delay; k++) begin
      // stray ready on the channel that is not granted must be ignored
      if (obs_wr) main_mem_out_ready = 1'($urandom_range(0, 1));
      else        main_mem_in_ready  = 1'($urandom_range(0, 1));
      main_mem_out_data = $urandom;
      #1;
      if (fetch_ready | exec_out_ready | exec_in_ready) obs_pulses++;
      if (main_mem_in_valid !== obs_wr || main_mem_out_valid !== !obs_wr ||
          (obs_wr ? main_mem_in_addr : main_mem_out_addr) !== obs_addr ||
          (obs_wr && main_mem_in_data !== obs_wdata)) obs_stable = 1'b0;
      @(negedge clk);
    end
    main_mem_out_ready = 1'b0; main_mem_in_ready = 1'b0;
    main_mem_out_data  = rdata;
    if (obs_wr) main_mem_in_ready = 1'b1;
    else        main_mem_out_ready = 1'b1;
    #1;
    obs_wdata_end = main_mem_in_data;
    obs_fd = fetch_data; obs_ed = exec_out_data;
    obs_pulses += int'(fetch_ready) + int'(exec_out_ready) + int'(exec_in_ready);
    if (exec_in_ready)       obs_kind = EXEC_WRITE;
    else if (exec_out_ready) obs_kind = EXEC_READ;
    else if (fetch_ready)    obs_kind = FETCH;
    @(negedge clk);
    main_mem_out_ready = 1'b0; main_mem_in_ready = 1'b0;
    main_mem_out_data  = $urandom;
    #1;
    obs_idle_after = !(main_mem_out_valid | main_mem_in_valid);
    if (fetch_ready | exec_out_ready | exec_in_ready) obs_pulses++;
    obs_fd2 = fetch_data; obs_ed2 = exec_out_data;
  endtask

  task automatic test_reset();
    fetch_addr = '0; exec_out_addr = '0; exec_in_addr = '0; exec_in_data = '0;
    main_mem_out_data = 32'hFFFF_FFFF;
    apply_reset();
    #1;
    vectors++;
    if ({main_mem_out_valid, main_mem_in_valid, fetch_ready, exec_out_ready, exec_in_ready, timeout_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, want 000000",
               {main_mem_out_valid, main_mem_in_valid, fetch_ready, exec_out_ready, exec_in_ready, timeout_err});
    end
    vectors++;
    if (fetch_data !== 32'h0 || exec_out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got fetch=%h exec=%h, want 0", fetch_data, exec_out_data);
    end
    vectors++;
    if (main_mem_out_addr !== 32'h0 || main_mem_in_addr !== 32'h0 || main_mem_in_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got %h %h %h, want 0", main_mem_out_addr, main_mem_in_addr, main_mem_in_data);
    end
  endtask

  task automatic test_fetch_only();
    int ek; logic [31:0] ea, ew;
    fetch_addr = 32'h100; fetch_valid = 1'b1;
    predict(1'b1, 1'b0, 1'b0, ek, ea, ew);
    do_txn(3, 32'hDEADBEEF, 1'b0);
    fetch_valid = 1'b0;
    vectors++;
    if (obs_lat !== 1) begin miscompares++; $display("FAIL fetch_latency: got %0d, want 1", obs_lat); end
    vectors++;
    if (obs_addr !== 32'h100 || obs_wr !== 1'b0) begin
      miscompares++; $display("FAIL fetch_addr: got %h wr=%b, want 00000100 wr=0", obs_addr, obs_wr);
    end
    vectors++;
    if (obs_kind !== ek || obs_pulses !== 1) begin
      miscompares++; $display("FAIL fetch_ready: got kind=%0d pulses=%0d, want %0d/1", obs_kind, obs_pulses, ek);
    end
    vectors++;
    if (obs_fd !== 32'hDEADBEEF || obs_fd2 !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL fetch_data: got %h then %h, want deadbeef", obs_fd, obs_fd2);
    end
    vectors++;
    if (!obs_idle_after || !obs_stable) begin
      miscompares++; $display("FAIL fetch_idle: got idle=%b stable=%b, want 1/1", obs_idle_after, obs_stable);
    end
    exp_fetch_data = 32'hDEADBEEF;
    @(negedge clk);
  endtask

  task automatic test_exec_write();
    int ek; logic [31:0] ea, ew;
    exec_in_addr = 32'h40; exec_in_data = 32'h12345678; exec_in_valid = 1'b1;
    predict(1'b0, 1'b1, 1'b0, ek, ea, ew);
    do_txn(2, 32'h0BAD_0BAD, 1'b1);   // scramble zeroes exec_in_data after grant
    exec_in_valid = 1'b0;
    vectors++;
    if (obs_lat !== 1 || obs_kind !== ek || obs_pulses !== 1) begin
      miscompares++;
      $display("FAIL write_handshake: got lat=%0d kind=%0d pulses=%0d, want 1/%0d/1", obs_lat, obs_kind, obs_pulses, ek);
    end
    vectors++;
    if (obs_addr !== 32'h40 || obs_wdata !== 32'h12345678) begin
      miscompares++; $display("FAIL write_capture: got %h/%h, want 00000040/12345678", obs_addr, obs_wdata);
    end
    vectors++;
    if (obs_wdata_end !== 32'h12345678 || !obs_stable) begin
      miscompares++; $display("FAIL write_hold: got %h stable=%b, want 12345678 stable=1", obs_wdata_end, obs_stable);
    end
    vectors++;
    if (obs_fd !== exp_fetch_data || obs_ed !== exp_exec_data) begin
      miscompares++; $display("FAIL write_readports: got %h/%h, want %h/%h", obs_fd, obs_ed, exp_fetch_data, exp_exec_data);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int ek; logic [31:0] ea, ew; logic [31:0] rdat;
    apply_reset();
    fetch_addr = $urandom; exec_out_addr = $urandom;
    fetch_valid = 1'b1; exec_out_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      predict(1'b1, 1'b0, 1'b1, ek, ea, ew);
      rdat = $urandom;
      do_txn(int'($urandom_range(0, 3)), rdat, 1'b1);
      vectors++;
      if (obs_kind !== ((i % 2 == 0) ? FETCH : EXEC_READ) || obs_addr !== ea || obs_lat !== 1) begin
        miscompares++;
        $display("FAIL contention_%0d: got kind=%0d addr=%h lat=%0d, want kind=%0d addr=%h lat=1",
                 i, obs_kind, obs_addr, obs_lat, (i % 2 == 0) ? FETCH : EXEC_READ, ea);
      end
      if (ek == FETCH) exp_fetch_data = rdat; else exp_exec_data = rdat;
    end
    fetch_valid = 1'b0; exec_out_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_before_read();
    int ek; logic [31:0] ea, ew; logic [31:0] rdat;
    exec_in_addr = $urandom; exec_in_data = $urandom; exec_out_addr = $urandom;
    exec_in_valid = 1'b1; exec_out_valid = 1'b1;
    predict(1'b0, 1'b1, 1'b1, ek, ea, ew);
    do_txn(1, 32'h0, 1'b0);
    exec_in_valid = 1'b0;            // write done; read still pending
    vectors++;
    if (obs_kind !== EXEC_WRITE || obs_addr !== ea || obs_wdata !== ew) begin
      miscompares++; $display("FAIL wr_first: got kind=%0d addr=%h data=%h, want 3 %h %h", obs_kind, obs_addr, obs_wdata, ea, ew);
    end
    predict(1'b0, 1'b0, 1'b1, ek, ea, ew);
    rdat = $urandom;
    do_txn(2, rdat, 1'b0);
    exec_out_valid = 1'b0;
    vectors++;
    if (obs_kind !== EXEC_READ || obs_addr !== ea || obs_ed !== rdat || obs_ed2 !== rdat) begin
      miscompares++;
      $display("FAIL rd_second: got kind=%0d addr=%h data=%h/%h, want 2 %h %h", obs_kind, obs_addr, obs_ed, obs_ed2, ea, rdat);
    end
    exp_exec_data = rdat;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [2:0] m; int ek; logic [31:0] ea, ew, rdat, efd, eed;
      m = 3'($urandom_range(1, 7));
      fetch_addr = $urandom; exec_out_addr = $urandom; exec_in_addr = $urandom; exec_in_data = $urandom;
      fetch_valid = m[0]; exec_in_valid = m[1]; exec_out_valid = m[2];
      predict(m[0], m[1], m[2], ek, ea, ew);
      rdat = $urandom;
      do_txn(int'($urandom_range(0, 3)), rdat, 1'b1);
      fetch_valid = 1'b0; exec_in_valid = 1'b0; exec_out_valid = 1'b0;
      efd = (ek == FETCH) ? rdat : exp_fetch_data;
      eed = (ek == EXEC_READ) ? rdat : exp_exec_data;
      vectors++;
      if (obs_lat !== 1 || obs_kind !== ek || obs_pulses !== 1 || !obs_stable || !obs_idle_after) begin
        miscompares++;
        $display("FAIL random_%0d_handshake: got lat=%0d kind=%0d pulses=%0d stable=%b idle=%b, want 1/%0d/1/1/1",
                 n, obs_lat, obs_kind, obs_pulses, obs_stable, obs_idle_after, ek);
      end
      vectors++;
      if (obs_addr !== ea || (ek == EXEC_WRITE && obs_wdata !== ew)) begin
        miscompares++; $display("FAIL random_%0d_capture: got %h/%h, want %h/%h", n, obs_addr, obs_wdata, ea, ew);
      end
      vectors++;
      if (obs_fd !== efd || obs_ed !== eed || obs_fd2 !== efd || obs_ed2 !== eed) begin
        miscompares++;
        $display("FAIL random_%0d_data: got %h %h %h %h, want %h %h", n, obs_fd, obs_ed, obs_fd2, obs_ed2, efd, eed);
      end
      exp_fetch_data = efd; exp_exec_data = eed;
      @(negedge clk);
    end
    vectors++;
    if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL no_timeout: got %b, want 0", timeout_err); end
  endtask

  task automatic test_reset_mid_txn();
    exec_out_addr = 32'h200; exec_out_valid = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (main_mem_out_valid !== 1'b1 || main_mem_out_addr !== 32'h200) begin
      miscompares++; $display("FAIL midrst_grant: got %b %h, want 1 00000200", main_mem_out_valid, main_mem_out_addr);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (main_mem_out_valid !== 1'b0 || main_mem_in_valid !== 1'b0) begin
      miscompares++; $display("FAIL midrst_drop: got %b %b, want 0 0", main_mem_out_valid, main_mem_in_valid);
    end
    reset = 1'b0; exec_out_valid = 1'b0;
    model_reset();
    main_mem_out_ready = 1'b1; main_mem_out_data = 32'hBAD0_BAD0;
    #1;
    vectors++;
    if (exec_out_ready !== 1'b0 || fetch_ready !== 1'b0 || exec_out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_late_ready: got %b %b %h, want 0 0 0", exec_out_ready, fetch_ready, exec_out_data);
    end
    @(negedge clk);
    main_mem_out_ready = 1'b0;
    #1;
    vectors++;
    if (main_mem_out_valid !== 1'b0 || exec_out_data !== 32'h0) begin
      miscompares++; $display("FAIL midrst_idle: got %b %h, want 0 0", main_mem_out_valid, exec_out_data);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    fetch_addr = $urandom; fetch_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk); #1;
      if (i == 2) fetch_valid = 1'b0;   // withdrawn valid has no effect
      vectors++;
      if (main_mem_out_valid !== 1'b1 || timeout_err !== (i >= 5)) begin
        miscompares++;
        $display("FAIL timeout_cycle_%0d: got valid=%b err=%b, want 1 %b", i, main_mem_out_valid, timeout_err, i >= 5);
      end
    end
    apply_reset();
    #1;
    vectors++;
    if (timeout_err !== 1'b0 || main_mem_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL timeout_clear: got err=%b valid=%b, want 0 0", timeout_err, main_mem_out_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    fetch_valid = 1'b0; exec_out_valid = 1'b0; exec_in_valid = 1'b0;
    main_mem_out_ready = 1'b0; main_mem_in_ready = 1'b0;
    test_reset();
    test_fetch_only();
    test_exec_write();
    test_contention();
    test_write_before_read();
    test_random();
    test_reset_mid_txn();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between two requesters: instruction fetch (read-only) and the executor's memory element (read and write).
- Sits between the core and the memory controller.
- Both sides use the codebase's main_mem valid/ready convention:
  - "in" is the write channel: addr, data, valid, ready.
  - "out" is the read channel: addr, valid, data, ready.
- Addr and data are captured at grant. Downstream signals therefore stay stable even if a requester changes its inputs.

Parameters:
- TIMEOUT, 0: cycles a granted transaction may wait for memory ready before timeout_err is set. 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_addr  in  32  fetch read address
- fetch_valid  in  1  fetch read request
- fetch_ready  out  1  one-cycle pulse: fetch_data valid, transaction done
- fetch_data  out  32  read data to fetch
- exec_out_addr  in  32  executor read address
- exec_out_valid  in  1  executor read request
- exec_out_ready  out  1  one-cycle pulse: exec_out_data valid
- exec_out_data  out  32  read data to executor
- exec_in_addr  in  32  executor write address
- exec_in_data  in  32  executor write data
- exec_in_valid  in  1  executor write request
- exec_in_ready  out  1  one-cycle pulse: write accepted
- main_mem_out_addr  out  32  read address to memory
- main_mem_out_valid  out  1  read request to memory
- main_mem_out_data  in  32  read data from memory
- main_mem_out_ready  in  1  read data valid, one cycle
- main_mem_in_addr  out  32  write address to memory
- main_mem_in_data  out  32  write data to memory
- main_mem_in_valid  out  1  write request to memory
- main_mem_in_ready  in  1  write done, one cycle
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- FSM states: IDLE, FETCH_RD, EXEC_RD, EXEC_WR.
- Reset (synchronous, takes priority over everything, including mid-transaction):
  - state = IDLE; last_grant = EXEC, so fetch wins the first tie.
  - All captured addr/data registers = 0; timeout_err = 0; watchdog counter = 0.
  - Every valid/ready output is 0.
  - An in-flight memory transaction is abandoned. Its later ready pulse arrives in IDLE and is ignored.
- IDLE: samples requests and transitions on the next edge.
  - Executor candidate: exec_in_valid beats exec_out_valid (write before read).
  - If only fetch or only the executor requests, grant it.
  - If both request, grant the one that is not last_grant (round-robin). Update last_grant on grant.
  - On grant, capture the chosen addr (plus data for writes) into registers.
- Granted state:
  - Drive the matching main_mem_*_valid = 1 from the registers. All other downstream valids = 0.
  - Hold until that channel's memory ready.
  - In the ready cycle, route the pulse combinationally to the granted requester's ready. For reads, also pass main_mem_out_data to its data port.
  - Next state is IDLE.
  - Ready on the non-granted memory channel is ignored.
- Latency:
  - Request seen in IDLE at cycle t; downstream valid asserts at t+1.
  - Requester ready occurs in the same cycle as memory ready.
  - At least one IDLE cycle separates consecutive transactions.
- Requester obligations:
  - Hold valid until ready; drop it the cycle after ready.
  - A valid withdrawn after grant has no effect; the transaction completes.
- fetch_data and exec_out_data:
  - Equal main_mem_out_data while the respective read is granted.
  - Hold their last value otherwise; registered copy, 0 after reset.
- Watchdog (TIMEOUT > 0):
  - Counter clears on entering a granted state and increments each granted cycle without ready.
  - When the count reaches TIMEOUT, timeout_err sets. It stays set until reset.
  - The transaction keeps waiting; there is no forced abort.
- Outputs to requesters never assert ready in IDLE.

Test Plan:
1. Fetch only: fetch_addr=0x100, memory returns 0xDEADBEEF 3 cycles after valid. Expect main_mem_out_valid at t+1 with main_mem_out_addr=0x100; fetch_ready pulses once with fetch_data=0xDEADBEEF; IDLE on the next cycle.
2. Exec write: exec_in_addr=0x40, data=0x12345678. Expect main_mem_in_valid with addr/data latched. Change exec_in_data to 0 after grant; main_mem_in_data must stay 0x12345678. exec_in_ready pulses with main_mem_in_ready.
3. Continuous contention (fetch and exec read held): first grant goes to fetch after reset, then exec, then fetch, strictly alternating over 6 transactions.
4. exec_in_valid and exec_out_valid both high, fetch idle: write is granted first, read second.
5. Reset asserted while EXEC_RD waits for memory: all valids drop the next cycle and state = IDLE. A late main_mem_out_ready produces no exec_out_ready.
6. TIMEOUT=4, memory never responds: timeout_err rises after 4 granted cycles and stays high; it clears only on reset.
